regfile: RTL and testbench
==========================

# regfile

Integer register file with per-register pending-write scoreboard. Sits downstream of `writeback`: consumes its `data_out`/`rd_out` pair as the single write port and serves two combinational read ports to decode. Also tracks how many in-flight instructions target each register, so decode can stall on RAW hazards that forwarding cannot cover.

## Interface
- `NREG`, 32: architectural register count; x0 is hardwired zero.
- `XLEN`, 64: register width.
- `CNTW`, 2: pending-counter width; max outstanding writers per register is 2^CNTW-1 = 3.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low; deasserts synchronously to `clk` upstream.
- `wb_rd`  in  5  write index from `writeback` `rd_out`; 0 means no write.
- `wb_data`  in  XLEN  write data from `writeback` `data_out`.
- `rs1`, `rs2`  in  5 each  read indices from decode.
- `rs1_data`, `rs2_data`  out  XLEN each  read data.
- `rs1_busy`, `rs2_busy`  out  1 each  pending count of the indexed register is nonzero after this cycle's writeback/release.
- `iss`  in  1  decode issues an instruction writing `iss_rd`.
- `iss_rd`  in  5  destination of the issued instruction.
- `iss_full`  out  1  counter of `iss_rd` is at max; decode must not assert `iss`.
- `rel`  in  1  squashed instruction releases its reservation without writing.
- `rel_rd`  in  5  destination being released.
- `sb_err`  out  1  sticky protocol-error flag.

## Operation
- Storage: registers 1..31, XLEN bits each; index 0 reads 0 and is never written or counted.
- Write: at the clock edge, if `wb_rd`!=0, reg[`wb_rd`] <= `wb_data`.
- Read: `rsN_data` = 0 if `rsN`==0; `wb_data` if `rsN`==`wb_rd`!=0 (write-through bypass); else reg[`rsN`].
- Scoreboard: one CNTW-bit counter per register 1..31.
  - inc = `iss` && `iss_rd`!=0 && target matches.
  - dec = (`wb_rd`==target) + (`rel` && `rel_rd`==target); range 0..2.
  - next = cnt + inc - dec, computed at CNTW+2 bits.
- Boundaries:
  - next < 0 (underflow): counter clamps to 0 and `sb_err` sets.
  - next > 3 (overflow, `iss` while `iss_full`): counter holds 3 and `sb_err` sets.
  - Issue and writeback to the same register in the same cycle: net 0 change.
  - Writeback and release to the same register in the same cycle: decrement by 2.
- `rsN_busy`: (cnt[`rsN`] - dec[`rsN`]) > 0, evaluated combinationally with the same bypass view as the data. `rsN`==0 never reports busy.
- `iss_full`: cnt[`iss_rd`]==3 && `iss_rd`!=0. Same-cycle decrements are not credited, so the output is conservative.
- `sb_err` clears only on reset.

## Timing
- Reset (async, `rst_n`=0): all registers 0, all counters 0, `sb_err`=0. Outputs therefore read `rsN_data`=0, `rsN_busy`=0, `iss_full`=0 immediately.
- Reset mid-operation clears all state in the same instant; in-flight writes are lost.
- Read ports and `iss_full` are combinational; there are no pipeline registers.
- Write-to-read latency is 0 cycles via the bypass; the stored value is visible from the next cycle.
- Counter update latency is 1 edge. `rsN_busy` reflects same-cycle writeback/release but not same-cycle issue.

## Test plan
- Reset, then read all 32 indices -> every `rsN_data`=0, `rsN_busy`=0, `sb_err`=0.
- `wb_rd`=5, `wb_data`=0xDEADBEEF_00000005, `rs1`=5 same cycle -> `rs1_data`=0xDEADBEEF_00000005; next cycle with `wb_rd`=0 the value persists. `wb_rd`=0 with data 0xFF.. -> reading x0 gives 0.
- Issue x7 three times -> `iss_full`=1 with `iss_rd`=7 and `rs1_busy`=1 for `rs1`=7. Three writebacks to x7 -> `rs1_busy`=0 on the cycle of the last writeback, counter 0.
- Count(x3)=2, then same cycle `wb_rd`=3 and `rel`=1/`rel_rd`=3 -> count 0, `rs2_busy`=0 for `rs2`=3, `sb_err`=0.
- Count(x9)=1, `iss`=1/`iss_rd`=9 with `wb_rd`=9 same cycle -> count stays 1, busy stays 1.
- Writeback to x4 with count 0 -> `sb_err`=1 and sticky, count stays 0. Assert `rst_n`=0 mid-sequence -> `sb_err`, data and counters clear asynchronously.

Source files
------------

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_if
//  Description : Writeback, decode read, issue and release signals of regfile.
//  Revision    : 1.0
// ============================================================================
interface regfile_if #(
    parameter int XLEN = 64,
    parameter int IDXW = 5
) ();
    logic [IDXW-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [IDXW-1:0] rs1;
    logic [IDXW-1:0] rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            iss;
    logic [IDXW-1:0] iss_rd;
    logic            iss_full;
    logic            rel;
    logic [IDXW-1:0] rel_rd;
    logic            sb_err;

    modport master (
        output wb_rd, wb_data, rs1, rs2, iss, iss_rd, rel, rel_rd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_full, sb_err
    );

    modport slave (
        input  wb_rd, wb_data, rs1, rs2, iss, iss_rd, rel, rel_rd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_full, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : Register file with write-through bypass and pending-writer
//                scoreboard for RAW hazard stalls.
//  Revision    : 1.0
// ============================================================================
module regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 64,
    parameter int CNTW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    regfile_if.slave   bus
);
    localparam int              IDXW      = $clog2(NREG);
    localparam int              SW        = CNTW + 2;
    localparam logic [CNTW-1:0] C_CNT_MAX = '1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [CNTW-1:0] cnt_q  [NREG];
    logic [CNTW-1:0] cnt_d  [NREG];
    logic [1:0]      w_dec  [NREG];
    logic            sb_err_q;
    logic            sb_err_d;

    always_comb begin : p_next
        logic          w_inc;
        logic [SW-1:0] w_nxt;
        w_inc    = 1'b0;
        w_nxt    = '0;
        regs_d   = regs_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        w_dec    = '{default: '0};
        if (bus.wb_rd != '0) begin
            regs_d[bus.wb_rd] = bus.wb_data;
        end
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        // Signed-width next count so underflow shows as a set MSB.
        for (int i = 1; i < NREG; i++) begin
            w_dec[i] = {1'b0, (bus.wb_rd == IDXW'(i))}
                     + {1'b0, (bus.rel && (bus.rel_rd == IDXW'(i)))};
            w_inc    = bus.iss && (bus.iss_rd == IDXW'(i));
            w_nxt    = SW'(cnt_q[i]) + SW'(w_inc) - SW'(w_dec[i]);
            if (w_nxt[SW-1]) begin
                cnt_d[i] = '0;
                sb_err_d = 1'b1;
            end else if (w_nxt > SW'(C_CNT_MAX)) begin
                cnt_d[i] = C_CNT_MAX;
                sb_err_d = 1'b1;
            end else begin
                cnt_d[i] = w_nxt[CNTW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            regs_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Busy credits same-cycle writeback/release but not same-cycle issue.
    assign bus.rs1_data = (bus.rs1 == '0)        ? '0 :
                          (bus.rs1 == bus.wb_rd) ? bus.wb_data : regs_q[bus.rs1];
    assign bus.rs2_data = (bus.rs2 == '0)        ? '0 :
                          (bus.rs2 == bus.wb_rd) ? bus.wb_data : regs_q[bus.rs2];
    assign bus.rs1_busy = (bus.rs1 != '0) && (SW'(cnt_q[bus.rs1]) > SW'(w_dec[bus.rs1]));
    assign bus.rs2_busy = (bus.rs2 != '0) && (SW'(cnt_q[bus.rs2]) > SW'(w_dec[bus.rs2]));
    assign bus.iss_full = (bus.iss_rd != '0) && (cnt_q[bus.iss_rd] == C_CNT_MAX);
    assign bus.sb_err   = sb_err_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile
//  Description : Vector table, corner sequences and random run against a model.
//  Revision    : 1.0
// ============================================================================
module tb_regfile;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int CNTW = 2;
    localparam int IW   = 5;
    localparam logic [63:0] D1 = 64'hDEADBEEF_00000005;
    localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_if #(.XLEN(XLEN), .IDXW(IW)) bus ();

    regfile #(.NREG(NREG), .XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  wb_rd;  logic [63:0] wb_data;
        logic [4:0]  rs1;    logic [4:0]  rs2;
        logic        iss;    logic [4:0]  iss_rd;
        logic        rel;    logic [4:0]  rel_rd;
        logic [63:0] e_d1;   logic        e_b1;
        logic [63:0] e_d2;   logic        e_b2;
        logic        e_full; logic        e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t ovf[$];

    // Reference model state
    logic [63:0] m_reg [NREG];
    int          m_cnt [NREG];
    bit          m_err;

    function automatic vec_t mk(input logic [4:0] wr, input logic [63:0] wd,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic is, input logic [4:0] ir,
                                input logic rl, input logic [4:0] rr,
                                input logic [63:0] d1, input logic b1,
                                input logic [63:0] d2, input logic b2,
                                input logic fu, input logic er);
        vec_t v;
        v.wb_rd = wr; v.wb_data = wd; v.rs1 = r1; v.rs2 = r2;
        v.iss = is; v.iss_rd = ir; v.rel = rl; v.rel_rd = rr;
        v.e_d1 = d1; v.e_b1 = b1; v.e_d2 = d2; v.e_b2 = b2;
        v.e_full = fu; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] wr, input logic [63:0] wd,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic is, input logic [4:0] ir,
                          input logic rl, input logic [4:0] rr);
        bus.wb_rd = wr; bus.wb_data = wd; bus.rs1 = r1; bus.rs2 = r2;
        bus.iss = is; bus.iss_rd = ir; bus.rel = rl; bus.rel_rd = rr;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        set_in(v.wb_rd, v.wb_data, v.rs1, v.rs2, v.iss, v.iss_rd, v.rel, v.rel_rd);
        #1;
        chk({tag, " rs1_data"}, bus.rs1_data, v.e_d1);
        chk({tag, " rs1_busy"}, 64'(bus.rs1_busy), 64'(v.e_b1));
        chk({tag, " rs2_data"}, bus.rs2_data, v.e_d2);
        chk({tag, " rs2_busy"}, 64'(bus.rs2_busy), 64'(v.e_b2));
        chk({tag, " iss_full"}, 64'(bus.iss_full), 64'(v.e_full));
        chk({tag, " sb_err"},   64'(bus.sb_err),   64'(v.e_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [63:0] m_read(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (idx == bus.wb_rd) return bus.wb_data;
        return m_reg[idx];
    endfunction

    function automatic int m_dec(input int t);
        return int'(bus.wb_rd == 5'(t)) + int'(bus.rel && bus.rel_rd == 5'(t));
    endfunction

    task automatic random_cycle(input int n);
        logic [4:0]  wr;
        logic [63:0] wd;
        @(negedge clk);
        wr = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
        wd = {$urandom, $urandom};
        set_in(wr, wd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
               ($urandom_range(0, 5) == 0), 5'($urandom_range(0, 7)));
        #1;
        chk($sformatf("rnd%0d rs1_data", n), bus.rs1_data, m_read(bus.rs1));
        chk($sformatf("rnd%0d rs2_data", n), bus.rs2_data, m_read(bus.rs2));
        chk($sformatf("rnd%0d rs1_busy", n), 64'(bus.rs1_busy),
            64'(bus.rs1 != 0 && (m_cnt[bus.rs1] - m_dec(int'(bus.rs1))) > 0));
        chk($sformatf("rnd%0d rs2_busy", n), 64'(bus.rs2_busy),
            64'(bus.rs2 != 0 && (m_cnt[bus.rs2] - m_dec(int'(bus.rs2))) > 0));
        chk($sformatf("rnd%0d iss_full", n), 64'(bus.iss_full),
            64'(bus.iss_rd != 0 && m_cnt[bus.iss_rd] == 3));
        chk($sformatf("rnd%0d sb_err", n), 64'(bus.sb_err), 64'(m_err));
        for (int t = 1; t < NREG; t++) begin
            int nx;
            nx = m_cnt[t] + int'(bus.iss && bus.iss_rd == 5'(t)) - m_dec(t);
            if (nx < 0) begin nx = 0; m_err = 1'b1; end
            if (nx > 3) begin nx = 3; m_err = 1'b1; end
            m_cnt[t] = nx;
        end
        if (bus.wb_rd != 0) m_reg[bus.wb_rd] = bus.wb_data;
    endtask

    initial begin
        //        wb  data        rs1 rs2 iss ird rel rrd  d1         b1 d2         b2 fu er
        tbl.push_back(mk(0,  0,          0, 31, 0, 0, 0, 0, 0,         0, 0,         0, 0, 0));
        tbl.push_back(mk(0,  0,          5,  5, 1, 5, 0, 0, 0,         0, 0,         0, 0, 0));
        tbl.push_back(mk(5,  D1,         5,  6, 0, 5, 0, 0, D1,        0, 0,         0, 0, 0));
        tbl.push_back(mk(0,  0,          5,  0, 0, 0, 0, 0, D1,        0, 0,         0, 0, 0));
        tbl.push_back(mk(0,  FF,         0,  5, 0, 0, 0, 0, 0,         0, D1,        0, 0, 0));
        tbl.push_back(mk(0,  0,          7,  0, 1, 7, 0, 0, 0,         0, 0,         0, 0, 0));
        tbl.push_back(mk(0,  0,          7,  0, 1, 7, 0, 0, 0,         1, 0,         0, 0, 0));
        tbl.push_back(mk(0,  0,          7,  0, 1, 7, 0, 0, 0,         1, 0,         0, 0, 0));
        tbl.push_back(mk(0,  0,          7,  0, 0, 7, 0, 0, 0,         1, 0,         0, 1, 0));
        tbl.push_back(mk(7,  64'h1111,   7,  0, 0, 7, 0, 0, 64'h1111,  1, 0,         0, 1, 0));
        tbl.push_back(mk(7,  64'h2222,   7,  0, 0, 7, 0, 0, 64'h2222,  1, 0,         0, 0, 0));
        tbl.push_back(mk(7,  64'h3333,   7,  7, 0, 7, 0, 0, 64'h3333,  0, 64'h3333,  0, 0, 0));
        tbl.push_back(mk(0,  0,          7,  3, 1, 3, 0, 0, 64'h3333,  0, 0,         0, 0, 0));
        tbl.push_back(mk(0,  0,          0,  3, 1, 3, 0, 0, 0,         0, 0,         1, 0, 0));
        tbl.push_back(mk(3,  64'hAB,     0,  3, 0, 3, 1, 3, 0,         0, 64'hAB,    0, 0, 0));
        tbl.push_back(mk(0,  0,          3,  0, 1, 9, 0, 0, 64'hAB,    0, 0,         0, 0, 0));
        tbl.push_back(mk(9,  64'h99,     9,  3, 1, 9, 0, 0, 64'h99,    0, 64'hAB,    0, 0, 0));
        tbl.push_back(mk(0,  0,          9,  0, 0, 9, 0, 0, 64'h99,    1, 0,         0, 0, 0));
        tbl.push_back(mk(4,  64'h44,     4,  9, 0, 0, 0, 0, 64'h44,    0, 64'h99,    1, 0, 0));
        tbl.push_back(mk(0,  0,          4,  9, 0, 0, 0, 0, 64'h44,    0, 64'h99,    1, 0, 1));
        tbl.push_back(mk(0,  0,          0,  0, 1, 0, 1, 0, 0,         0, 0,         0, 0, 1));
        tbl.push_back(mk(0,  0,          0,  9, 0, 0, 0, 0, 0,         0, 64'h99,    1, 0, 1));

        // Overflow: fourth issue must saturate at 3, not wrap
        ovf.push_back(mk(0,  0,          12, 0, 1, 12, 0, 0, 0,        0, 0,         0, 0, 0));
        ovf.push_back(mk(0,  0,          12, 0, 1, 12, 0, 0, 0,        1, 0,         0, 0, 0));
        ovf.push_back(mk(0,  0,          12, 0, 1, 12, 0, 0, 0,        1, 0,         0, 0, 0));
        ovf.push_back(mk(0,  0,          12, 0, 1, 12, 0, 0, 0,        1, 0,         0, 1, 0));
        ovf.push_back(mk(12, 64'h12,     12, 0, 0, 12, 0, 0, 64'h12,   1, 0,         0, 1, 1));
        ovf.push_back(mk(12, 64'h13,     12, 0, 0, 12, 0, 0, 64'h13,   1, 0,         0, 0, 1));
        ovf.push_back(mk(12, 64'h14,     12, 0, 0, 12, 0, 0, 64'h14,   0, 0,         0, 0, 1));
        ovf.push_back(mk(0,  0,          12, 0, 0, 12, 0, 0, 64'h14,   0, 0,         0, 0, 1));

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("async_reset rs1_data", bus.rs1_data, 64'h0);
        chk("async_reset sb_err", 64'(bus.sb_err), 64'h0);
        do_reset();

        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            set_in(0, 0, 5'(i), 5'(NREG - 1 - i), 0, 5'(i), 0, 0);
            #1;
            chk($sformatf("rst x%0d rs1_data", i), bus.rs1_data, 64'h0);
            chk($sformatf("rst x%0d rs2_data", i), bus.rs2_data, 64'h0);
            chk($sformatf("rst x%0d rs1_busy", i), 64'(bus.rs1_busy), 64'h0);
            chk($sformatf("rst x%0d rs2_busy", i), 64'(bus.rs2_busy), 64'h0);
            chk($sformatf("rst x%0d iss_full", i), 64'(bus.iss_full), 64'h0);
            chk($sformatf("rst x%0d sb_err", i),   64'(bus.sb_err),   64'h0);
        end

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset between clock edges
        @(negedge clk);
        set_in(0, 0, 9, 5, 0, 9, 0, 0);
        #1;
        chk("pre_rst rs1_busy", 64'(bus.rs1_busy), 64'h1);
        chk("pre_rst rs2_data", bus.rs2_data, D1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst rs1_data", bus.rs1_data, 64'h0);
        chk("mid_rst rs1_busy", 64'(bus.rs1_busy), 64'h0);
        chk("mid_rst rs2_data", bus.rs2_data, 64'h0);
        chk("mid_rst sb_err",   64'(bus.sb_err),   64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (ovf[i]) apply(ovf[i], $sformatf("ovf%0d", i));

        do_reset();
        for (int n = 0; n < 400; n++) random_cycle(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
